spi_target_lite: RTL and testbench
==================================

// Module: spi_target_lite
// PURPOSE
// - Oversampled SPI target (responder) for the SPI host: mode 0 (CPOL=0, CPHA=0), single lane, MSB first.
// - Samples SCK/CSB/SDI in the clk_i domain; no SCK-clocked logic.
// - Delivers received bytes on a valid/ready stream; transmits bytes taken from a valid/ready stream.
// - Used as a chip-level loopback target and as a peripheral-side bridge; pads are driven via cio_* style out/en.
// PARAMETERS
// - SyncStages  2      synchroniser depth on sck_i/csb_i/sdi_i (>=2)
// - TxIdleByte  8'hFF  byte shifted out when no TX data is available at a byte boundary
// PORTS
// - clk_i           in   1  sole clock; SCK freq must be <= clk_i/8
// - rst_i           in   1  synchronous, active-high reset
// - cio_sck_i       in   1  SPI clock from host (asynchronous)
// - cio_csb_i       in   1  chip select, active low (asynchronous)
// - cio_sdi_i       in   1  host-to-target data (COPI)
// - cio_sdo_o       out  1  target-to-host data (CIPO)
// - cio_sdo_en_o    out  1  CIPO output enable; high only while selected
// - rx_valid_o      out  1  received byte available
// - rx_data_o       out  8  received byte; stable while rx_valid_o && !rx_ready_i
// - rx_ready_i      in   1  consumer accepts rx_data_o
// - tx_valid_i      in   1  TX byte offered
// - tx_data_i       in   8  TX byte
// - tx_ready_o      out  1  one-cycle pulse: tx_data_i taken this cycle
// - rx_overflow_o   out  1  one-cycle pulse: byte completed while RX holding reg full; new byte dropped
// - tx_underflow_o  out  1  one-cycle pulse: byte boundary with !tx_valid_i; TxIdleByte used
// - frame_done_o    out  1  one-cycle pulse: CSB deasserted (end of frame)
// BEHAVIOUR
// - Inputs pass SyncStages flops, then 1 history flop; sck_rise/sck_fall/csb_fall/csb_rise are 1-cycle pulses.
// - Reset: state=Idle, bit_cnt=0, shift regs 0, rx holding reg empty; all outputs 0.
// - FSM Idle -> Active on csb_fall. Active -> Idle on csb_rise (frame_done_o pulses same cycle).
// - Load (at csb_fall, and at sck_fall when bit_cnt==0 in Active): tx_valid_i ? (tx_sh<=tx_data_i, tx_ready_o=1)
//   : (tx_sh<=TxIdleByte, tx_underflow_o=1).
// - cio_sdo_o = tx_sh[7]; cio_sdo_en_o = (state==Active). Both registered; first bit valid 1 cycle after csb_fall.
// - sck_rise in Active: rx_sh<={rx_sh[6:0],sdi_sync}; bit_cnt<=bit_cnt+1 (3 bits, wraps 7->0).
//   On the rise with bit_cnt==7: byte complete. If holding empty, or (rx_valid_o && rx_ready_i) same cycle,
//   write {rx_sh[6:0],sdi_sync} to holding, rx_valid_o=1 next cycle. Else rx_overflow_o pulse, holding unchanged.
// - sck_fall in Active with bit_cnt!=0: tx_sh<={tx_sh[6:0],1'b0}.
// - rx handshake: rx_valid_o clears the cycle after rx_valid_o && rx_ready_i unless refilled that cycle.
// - Latency: pad edge -> internal pulse = SyncStages+1 cycles; byte complete -> rx_valid_o = +1 cycle.
// - csb_rise mid-byte: partial rx bits discarded, bit_cnt<=0, no rx write, no pulse besides frame_done_o.
// - csb_rise and sck edge in same cycle: csb_rise wins, SCK edge ignored.
// - csb_fall and csb_rise cannot coincide; SCK edges in Idle are ignored. TX data offered in Idle is not taken.
// - rst_i mid-frame: return to Idle; target stays idle until the next csb_fall (no resync mid-frame).
// - Holding register survives frame end: unread byte stays valid across CSB toggles.
// STRUCTURE
// - spi_target_pkg: state enum {StIdle, StActive}, ByteW=8, BitCntW=3.
// - Sub-module spi_target_sync: SyncStages synchroniser + history flop + rise/fall pulse generation
//   (one instance per input; sdi uses same depth so it stays aligned with sck).
// - Top: FSM, bit counter, rx/tx shift registers, RX holding register, status pulses.
// TESTING
// - Host sends 8'hA5 with tx_valid_i=1,tx_data_i=8'h3C, rx_ready_i=1 -> rx_data_o=8'hA5 one pulse; host reads 8'h3C.
// - 3-byte frame 8'h01,8'h02,8'h03 with rx_ready_i=0 -> holding=8'h01, rx_overflow_o pulses twice, 8'h01 kept.
// - tx_valid_i=0 for whole 2-byte frame -> host reads 8'hFF,8'hFF; tx_underflow_o pulses twice; tx_ready_o never high.
// - CSB released after 5 SCK rises -> frame_done_o pulse, no rx_valid_o; next frame 8'h5A received correctly.
// - rst_i asserted after 4 bits, held 2 cycles -> outputs 0, sdo_en 0; bits ignored until next CSB fall, then 8'hC3 ok.
// - SCK = clk_i/8, back-to-back bytes with rx_ready_i toggling 1/0 each cycle -> no drop, 16 bytes in order.

Source files
------------

// File: rtl/spi_target_pkg.sv
// Shared types and widths for the oversampled SPI target.
package spi_target_pkg;

  localparam int ByteW   = 8;
  localparam int BitCntW = 3;

  typedef enum logic {
    StIdle   = 1'b0,
    StActive = 1'b1
  } state_e;

endpackage

// File: rtl/spi_target_sync.sv
// Synchroniser plus history flop for one asynchronous pad input.
// Produces the synchronised level and single-cycle rise/fall pulses.
// The chain resets low, so a chip select that is already low when reset
// releases never produces a falling edge: the target stays idle until
// the host toggles chip select again.
module spi_target_sync #(
  parameter int SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SyncStages-1:0] sync_q;
  logic                  hist_q;

  // Shift the pad value through the synchroniser, then keep one cycle of history.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], d_i};
      hist_q <= sync_q[SyncStages-1];
    end
  end

  assign level_o = sync_q[SyncStages-1];
  assign rise_o  = level_o & ~hist_q;
  assign fall_o  = ~level_o & hist_q;

endmodule

// File: rtl/spi_target_lite.sv
// SPI mode-0 target, oversampled in the clk_i domain.
// Handshakes: a stream transfer happens on a clk_i edge where valid and
// ready are both high; rx_data_o holds steady while rx_valid_o && !rx_ready_i,
// and tx_ready_o is high exactly in the cycle tx_data_i is loaded.
module spi_target_lite
  import spi_target_pkg::*;
#(
  parameter int         SyncStages = 2,
  parameter logic [7:0] TxIdleByte = 8'hFF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cio_sck_i,
  input  logic             cio_csb_i,
  input  logic             cio_sdi_i,
  output logic             cio_sdo_o,
  output logic             cio_sdo_en_o,
  output logic             rx_valid_o,
  output logic [ByteW-1:0] rx_data_o,
  input  logic             rx_ready_i,
  input  logic             tx_valid_i,
  input  logic [ByteW-1:0] tx_data_i,
  output logic             tx_ready_o,
  output logic             rx_overflow_o,
  output logic             tx_underflow_o,
  output logic             frame_done_o
);

  logic sck_lvl, sck_rise, sck_fall;
  logic csb_lvl, csb_rise, csb_fall;
  logic sdi_lvl, sdi_rise, sdi_fall;
  logic unused_sync;

  spi_target_sync #(.SyncStages(SyncStages)) u_sync_sck (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(cio_sck_i),
    .level_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_target_sync #(.SyncStages(SyncStages)) u_sync_csb (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(cio_csb_i),
    .level_o(csb_lvl), .rise_o(csb_rise), .fall_o(csb_fall)
  );

  // Same depth as SCK so the data bit stays aligned with its clock edge.
  spi_target_sync #(.SyncStages(SyncStages)) u_sync_sdi (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(cio_sdi_i),
    .level_o(sdi_lvl), .rise_o(sdi_rise), .fall_o(sdi_fall)
  );

  assign unused_sync = ^{sck_lvl, csb_lvl, sdi_rise, sdi_fall};

  state_e               state_q;
  logic [BitCntW-1:0]   bit_cnt_q;
  logic [ByteW-1:0]     rx_sh_q;
  logic [ByteW-1:0]     tx_sh_q;
  logic [ByteW-1:0]     hold_q;
  logic                 rx_valid_q;
  logic                 rx_ovf_q;
  logic                 tx_udf_q;
  logic                 frame_done_q;

  logic                 load_evt;
  logic                 hold_free;
  logic [ByteW-1:0]     rx_byte_d;
  logic [ByteW-1:0]     tx_load_d;

  // A TX byte is loaded at selection and at the first falling SCK edge of
  // every following byte; a simultaneous deselect suppresses the latter.
  assign load_evt  = !rst_i &&
                     (((state_q == StIdle) && csb_fall) ||
                      ((state_q == StActive) && !csb_rise && sck_fall && (bit_cnt_q == '0)));
  assign tx_load_d = tx_valid_i ? tx_data_i : TxIdleByte;
  assign rx_byte_d = {rx_sh_q[ByteW-2:0], sdi_lvl};
  assign hold_free = !rx_valid_q || rx_ready_i;

  // Frame FSM, bit counter, shift registers, RX holding register and status pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      rx_sh_q      <= '0;
      tx_sh_q      <= '0;
      hold_q       <= '0;
      rx_valid_q   <= 1'b0;
      rx_ovf_q     <= 1'b0;
      tx_udf_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      rx_ovf_q     <= 1'b0;
      tx_udf_q     <= 1'b0;
      frame_done_q <= 1'b0;

      if (rx_valid_q && rx_ready_i) begin
        rx_valid_q <= 1'b0;
      end

      if (load_evt) begin
        tx_sh_q  <= tx_load_d;
        tx_udf_q <= !tx_valid_i;
      end

      unique case (state_q)
        StIdle: begin
          if (csb_fall) begin
            state_q   <= StActive;
            bit_cnt_q <= '0;
            rx_sh_q   <= '0;
          end
        end
        StActive: begin
          if (csb_rise) begin
            // Deselect wins over any SCK edge seen in the same cycle.
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            rx_sh_q      <= '0;
            frame_done_q <= 1'b1;
          end else begin
            if (sck_rise) begin
              rx_sh_q   <= rx_byte_d;
              bit_cnt_q <= bit_cnt_q + BitCntW'(1);
              if (bit_cnt_q == '1) begin
                if (hold_free) begin
                  hold_q     <= rx_byte_d;
                  rx_valid_q <= 1'b1;
                end else begin
                  rx_ovf_q <= 1'b1;
                end
              end
            end
            if (sck_fall && (bit_cnt_q != '0)) begin
              tx_sh_q <= {tx_sh_q[ByteW-2:0], 1'b0};
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cio_sdo_o      = tx_sh_q[ByteW-1];
  assign cio_sdo_en_o   = (state_q == StActive);
  assign rx_valid_o     = rx_valid_q;
  assign rx_data_o      = hold_q;
  assign tx_ready_o     = load_evt && tx_valid_i;
  assign rx_overflow_o  = rx_ovf_q;
  assign tx_underflow_o = tx_udf_q;
  assign frame_done_o   = frame_done_q;

endmodule

// File: tb/tb_spi_target_lite.sv
// Bench for spi_target_lite: a host task bit-bangs SPI frames, a frame-level
// model predicts received bytes, host-read bytes and pulse counts.
module tb_spi_target_lite;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       cio_sck_i, cio_csb_i, cio_sdi_i;
  logic       cio_sdo_o, cio_sdo_en_o;
  logic       rx_valid_o;
  logic [7:0] rx_data_o;
  logic       rx_ready_i;
  logic       tx_valid_i;
  logic [7:0] tx_data_i;
  logic       tx_ready_o;
  logic       rx_overflow_o, tx_underflow_o, frame_done_o;

  // clock / reset
  always #5 clk_i = ~clk_i;

  spi_target_lite #(.SyncStages(2), .TxIdleByte(8'hFF)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cio_sck_i(cio_sck_i), .cio_csb_i(cio_csb_i), .cio_sdi_i(cio_sdi_i),
    .cio_sdo_o(cio_sdo_o), .cio_sdo_en_o(cio_sdo_en_o),
    .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o), .rx_ready_i(rx_ready_i),
    .tx_valid_i(tx_valid_i), .tx_data_i(tx_data_i), .tx_ready_o(tx_ready_o),
    .rx_overflow_o(rx_overflow_o), .tx_underflow_o(tx_underflow_o),
    .frame_done_o(frame_done_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];      // bytes the consumer must see, in order
  logic [7:0] tx_src_q[$];   // bytes offered on the TX stream
  logic [7:0] host_tx_q[$];  // bytes the host shifts out this frame
  logic [7:0] host_rx_q[$];  // bytes the host read back this frame
  logic [7:0] exp_host[$];   // bytes the host must read this frame

  bit  tx_en      = 1'b0;
  int  ready_mode = 0;       // 0: always ready, 1: never ready, 2: toggle each cycle
  bit  armed      = 1'b0;    // host selected the target since the last reset
  bit  hold_model = 1'b0;    // model view of the holding register being full

  int cnt_ovf = 0, cnt_udf = 0, cnt_fd = 0, cnt_rdy = 0, cnt_rx = 0;
  int d_ovf, d_udf, d_fd, d_rdy, d_rx;
  int b_ovf, b_udf, b_fd, b_rdy, b_rx;
  logic [7:0] last_rx = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // scoreboard / compare process: stream handshakes, stability, pulse widths, output enable
  initial begin : monitor
    logic p_valid, p_ready, p_rst, p_ovf, p_udf, p_fd, p_csb;
    logic [7:0] p_data;
    int csb_stable, cyc;
    p_valid = 1'b0; p_ready = 1'b0; p_rst = 1'b1; p_ovf = 1'b0; p_udf = 1'b0;
    p_fd = 1'b0; p_csb = 1'b1; p_data = 8'h00; csb_stable = 0; cyc = 0;
    forever begin
      @(negedge clk_i);
      cyc++;
      tx_valid_i = tx_en && (tx_src_q.size() > 0);
      tx_data_i  = tx_valid_i ? tx_src_q[0] : 8'h00;
      case (ready_mode)
        0:       rx_ready_i = 1'b1;
        1:       rx_ready_i = 1'b0;
        default: rx_ready_i = ((cyc % 2) == 1);
      endcase
      #1;
      if (cio_csb_i !== p_csb) csb_stable = 0;
      else if (csb_stable < 1000) csb_stable++;
      if (!rst_i) begin
        if (!p_rst && p_valid && !p_ready) begin
          check("rx_valid_held", rx_valid_o, 1'b1);
          check("rx_data_held", rx_data_o, p_data);
        end
        if (rx_valid_o && rx_ready_i) begin
          cnt_rx++;
          last_rx = rx_data_o;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL rx_unexpected: got byte %0h, expected no byte", rx_data_o);
          end else begin
            check("rx_data", rx_data_o, exp_q.pop_front());
          end
        end
        if (tx_ready_o) begin
          check("tx_ready_only_with_valid", tx_valid_i, 1'b1);
          if (tx_valid_i) begin
            cnt_rdy++;
            void'(tx_src_q.pop_front());
          end
        end
        if (rx_overflow_o)  cnt_ovf++;
        if (tx_underflow_o) cnt_udf++;
        if (frame_done_o)   cnt_fd++;
        if (p_ovf) check("ovf_one_cycle", rx_overflow_o, 1'b0);
        if (p_udf) check("udf_one_cycle", tx_underflow_o, 1'b0);
        if (p_fd)  check("frame_done_one_cycle", frame_done_o, 1'b0);
        if (csb_stable >= 4) check("sdo_en", cio_sdo_en_o, (!cio_csb_i) && armed);
      end
      p_valid = rx_valid_o; p_ready = rx_ready_i; p_data = rx_data_o; p_rst = rst_i;
      p_ovf = rx_overflow_o; p_udf = tx_underflow_o; p_fd = frame_done_o; p_csb = cio_csb_i;
    end
  end

  // frame-level model: what a frame of nbits must produce
  task automatic model_frame(input int nbits);
    int k, slots, nfull;
    k = 0;
    nfull = nbits / 8;
    slots = 1 + (nbits - 1) / 8;
    d_ovf = 0; d_udf = 0; d_fd = 1; d_rdy = 0; d_rx = 0;
    exp_host.delete();
    for (int s = 0; s < slots; s++) begin
      if (tx_en && k < tx_src_q.size()) begin
        exp_host.push_back(tx_src_q[k]);
        k++;
        d_rdy++;
      end else begin
        exp_host.push_back(8'hFF);
        d_udf++;
      end
    end
    if (ready_mode != 1) hold_model = 1'b0;
    for (int i = 0; i < nfull; i++) begin
      if (ready_mode == 1) begin
        if (hold_model) d_ovf++;
        else begin
          exp_q.push_back(host_tx_q[i]);
          hold_model = 1'b1;
        end
      end else begin
        exp_q.push_back(host_tx_q[i]);
        d_rx++;
      end
    end
  endtask

  task automatic snap();
    b_ovf = cnt_ovf; b_udf = cnt_udf; b_fd = cnt_fd; b_rdy = cnt_rdy; b_rx = cnt_rx;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_sdo"}, cio_sdo_o, 1'b0);
    check({tag, "_sdo_en"}, cio_sdo_en_o, 1'b0);
    check({tag, "_rx_valid"}, rx_valid_o, 1'b0);
    check({tag, "_rx_data"}, rx_data_o, 8'h00);
    check({tag, "_tx_ready"}, tx_ready_o, 1'b0);
    check({tag, "_ovf"}, rx_overflow_o, 1'b0);
    check({tag, "_udf"}, tx_underflow_o, 1'b0);
    check({tag, "_frame_done"}, frame_done_o, 1'b0);
  endtask

  task automatic do_reset_mid();
    rst_i = 1'b1;
    armed = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    exp_q.delete();
    hold_model = 1'b0;
    check_outputs_zero("midreset");
  endtask

  // driver: host frame, SCK half period h in [hmin,hmax] clk cycles
  task automatic host_frame(input int nbits, input int hmin, input int hmax, input int rst_bit);
    logic [7:0] rd, cur;
    int h;
    rd = 8'h00;
    host_rx_q.delete();
    cio_csb_i = 1'b0;
    armed = 1'b1;
    repeat (6) @(negedge clk_i);
    for (int b = 0; b < nbits; b++) begin
      if (b == rst_bit) do_reset_mid();
      cur = host_tx_q[b / 8];
      cio_sdi_i = cur[7 - (b % 8)];
      h = $urandom_range(hmax, hmin);
      repeat (h) @(negedge clk_i);
      rd = {rd[6:0], cio_sdo_o};
      if ((b % 8) == 7) host_rx_q.push_back(rd);
      cio_sck_i = 1'b1;
      repeat (h) @(negedge clk_i);
      cio_sck_i = 1'b0;
      if (b == nbits - 1) cio_csb_i = 1'b1;
    end
    repeat (10) @(negedge clk_i);
  endtask

  task automatic verify_frame(input string tag);
    check({tag, "_ovf_cnt"}, cnt_ovf - b_ovf, d_ovf);
    check({tag, "_udf_cnt"}, cnt_udf - b_udf, d_udf);
    check({tag, "_fd_cnt"}, cnt_fd - b_fd, d_fd);
    check({tag, "_txrdy_cnt"}, cnt_rdy - b_rdy, d_rdy);
    for (int i = 0; i < host_rx_q.size(); i++) check({tag, "_host_read"}, host_rx_q[i], exp_host[i]);
  endtask

  task automatic run_frame(input string tag, input int nbits, input int hmin, input int hmax);
    snap();
    model_frame(nbits);
    host_frame(nbits, hmin, hmax, -1);
    verify_frame(tag);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    int nb;
    rst_i = 1'b1; cio_sck_i = 1'b0; cio_csb_i = 1'b1; cio_sdi_i = 1'b0;
    rx_ready_i = 1'b1; tx_valid_i = 1'b0; tx_data_i = 8'h00;
    repeat (3) @(negedge clk_i);
    check_outputs_zero("reset");
    rst_i = 1'b0;
    repeat (8) @(negedge clk_i);

    // single byte exchange
    ready_mode = 0; tx_en = 1'b1; tx_src_q = '{8'h3C}; host_tx_q = '{8'hA5};
    run_frame("t1", 8, 4, 6);
    check("t1_host_lit", host_rx_q[0], 8'h3C);
    check("t1_rx_lit", last_rx, 8'hA5);
    check("t1_rx_cnt", cnt_rx - b_rx, 1);

    // consumer stalled: first byte held, later bytes dropped
    ready_mode = 1; tx_src_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
    host_tx_q = '{8'h01, 8'h02, 8'h03};
    run_frame("t2", 24, 4, 6);
    check("t2_ovf_lit", cnt_ovf - b_ovf, 2);
    check("t2_valid_lit", rx_valid_o, 1'b1);
    check("t2_data_lit", rx_data_o, 8'h01);

    // no TX data: idle bytes, held byte drains first
    ready_mode = 0; tx_en = 1'b0;
    host_tx_q = '{8'($urandom), 8'($urandom)};
    run_frame("t3", 16, 4, 6);
    check("t3_host0_lit", host_rx_q[0], 8'hFF);
    check("t3_host1_lit", host_rx_q[1], 8'hFF);
    check("t3_udf_lit", cnt_udf - b_udf, 2);
    check("t3_rdy_lit", cnt_rdy - b_rdy, 0);

    // deselect mid-byte, then a clean frame
    tx_en = 1'b1; tx_src_q = '{8'($urandom)}; host_tx_q = '{8'($urandom)};
    run_frame("t4a", 5, 4, 6);
    check("t4_fd_lit", cnt_fd - b_fd, 1);
    check("t4_rx_lit", cnt_rx - b_rx, 0);
    host_tx_q = '{8'h5A};
    run_frame("t4b", 8, 4, 6);
    check("t4_rx5a_lit", last_rx, 8'h5A);

    // reset after four bits, bits ignored until the next select
    tx_en = 1'b0; host_tx_q = '{8'($urandom)};
    snap();
    host_frame(8, 4, 5, 4);
    check("t5_udf_lit", cnt_udf - b_udf, 1);
    check("t5_fd_lit", cnt_fd - b_fd, 0);
    check("t5_rx_lit", cnt_rx - b_rx, 0);
    host_tx_q = '{8'hC3};
    run_frame("t5b", 8, 4, 6);
    check("t5_rxc3_lit", last_rx, 8'hC3);

    // SCK = clk/8, 16 back-to-back bytes, ready toggling every cycle
    ready_mode = 2; tx_en = 1'b1;
    tx_src_q.delete();
    for (int i = 0; i < 10; i++) tx_src_q.push_back(8'($urandom));
    host_tx_q.delete();
    for (int i = 0; i < 16; i++) host_tx_q.push_back(8'($urandom));
    run_frame("t6", 128, 4, 4);
    check("t6_rx_lit", cnt_rx - b_rx, 16);
    check("t6_ovf_lit", cnt_ovf - b_ovf, 0);

    // randomized frames
    for (int f = 0; f < 4; f++) begin
      ready_mode = ($urandom_range(1, 0) == 1) ? 2 : 0;
      tx_en = 1'($urandom_range(1, 0));
      for (int i = 0; i < int'($urandom_range(3, 0)); i++) tx_src_q.push_back(8'($urandom));
      nb = $urandom_range(3, 1);
      host_tx_q.delete();
      for (int i = 0; i < nb; i++) host_tx_q.push_back(8'($urandom));
      run_frame("rand", nb * 8, 4, 7);
      check("rand_rx_cnt", cnt_rx - b_rx, d_rx);
    end

    repeat (10) @(negedge clk_i);
    check("rx_queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
